// File: rtl/piso_arbiter.sv
// piso_arbiter: round-robin arbiter sharing one PISO serializer among NUM_REQ word producers,
// with an idle gap between transactions and a watchdog that aborts a missing done.
module piso_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int SIZE_DATA_IN = 16,
    parameter int SIZE_ID      = $clog2(NUM_REQ),
    parameter int GAP_CYC      = 2,
    parameter int TIMEOUT_CYC  = 32
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*SIZE_DATA_IN-1:0] i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_ser_start,
    output logic [SIZE_DATA_IN-1:0]         o_ser_data,
    input  logic                            i_ser_done,
    output logic [SIZE_ID-1:0]              o_grant_id,
    output logic                            o_busy,
    output logic                            o_timeout_err,
    input  logic                            i_err_clr
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam int GP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(GAP_CYC - 1);
    localparam logic [SIZE_ID:0] L_NREQ = (SIZE_ID + 1)'(NUM_REQ);

    state_t                    r_state;
    logic [SIZE_ID-1:0]        r_rr_ptr;
    logic [SIZE_ID-1:0]        r_grant_id;
    logic [SIZE_DATA_IN-1:0]   r_data;
    logic [WD_W-1:0]           r_wd;
    logic [GP_W-1:0]           r_gap;
    logic                      r_err;
    logic [2*NUM_REQ-1:0]      w_dbl;
    logic [NUM_REQ-1:0]        w_rot;
    logic [SIZE_ID-1:0]        w_off;
    logic [SIZE_ID:0]          w_sum;
    logic [SIZE_ID:0]          w_wrap;
    logic [SIZE_ID:0]          w_nx;
    logic [SIZE_ID-1:0]        w_win;
    logic [SIZE_ID-1:0]        w_rr_next;
    logic [SIZE_DATA_IN-1:0]   w_word;
    logic                      w_any;

    // Rotate valids so bit 0 is the rr_ptr requester; the lowest set bit is the winner offset.
    assign w_dbl = {i_req_valid, i_req_valid} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];
    assign w_any = |i_req_valid;

    always_comb begin
        w_off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (w_rot[i]) w_off = SIZE_ID'(i);
    end

    assign w_sum     = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_wrap    = (w_sum >= L_NREQ) ? w_sum - L_NREQ : w_sum;
    assign w_win     = w_wrap[SIZE_ID-1:0];
    assign w_nx      = {1'b0, w_win} + 1'b1;
    assign w_rr_next = (w_nx == L_NREQ) ? '0 : w_nx[SIZE_ID-1:0];

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (w_win == SIZE_ID'(k)) w_word = i_req_data[k*SIZE_DATA_IN +: SIZE_DATA_IN];
    end

    assign o_req_ready   = (r_state == IDLE && w_any) ? NUM_REQ'(1) << w_win : '0;
    assign o_ser_start   = (r_state == SEND);
    assign o_busy        = (r_state != IDLE);
    assign o_ser_data    = r_data;
    assign o_grant_id    = r_grant_id;
    assign o_timeout_err = r_err;

    // The timeout set is written after the clear so it wins when both happen together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_data     <= '0;
            r_wd       <= '0;
            r_gap      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (i_err_clr) r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_data     <= w_word;
                    r_grant_id <= w_win;
                    r_rr_ptr   <= w_rr_next;
                    r_wd       <= '0;
                    r_state    <= SEND;
                end
                SEND: if (i_ser_done) begin
                    r_state <= GAP;
                    r_gap   <= '0;
                end else if (r_wd == WD_LAST) begin
                    r_err   <= 1'b1;
                    r_state <= GAP;
                    r_gap   <= '0;
                end else begin
                    r_wd <= r_wd + 1'b1;
                end
                GAP: if (r_gap == GP_LAST) r_state <= IDLE;
                     else r_gap <= r_gap + 1'b1;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piso_arbiter.sv
// tb_piso_arbiter: directed stimulus with a transaction-level reference model checked every cycle,
// plus literal expectations on grant order, start/gap lengths and the sticky error.
module tb_piso_arbiter;
    localparam int N = 4, W = 16, ID = 2, GAPC = 2, TO = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic [N-1:0]     valid = '0;
    logic [N*W-1:0]   data;
    logic [N-1:0]     ready;
    logic             start;
    logic [W-1:0]     sdata;
    logic             ser_done = 1'b0;
    logic [ID-1:0]    gid;
    logic             busy;
    logic             err;
    logic             clr = 1'b0;

    logic [W-1:0] words [N];
    int           q_cnt [N];
    int           ser_len = 10, scnt = 0;
    logic         stray = 1'b0;
    int           errors = 0, checks = 0;

    int           m_phase = 0, m_sent = 0, m_gap = 0, m_rr = 0, m_grant = 0;
    logic [W-1:0] m_data = '0;
    logic         m_err = 1'b0;

    int           run = 0, gapc = 0, rdy_cyc = 0;
    int           q_runs[$], q_gaps[$], q_g[$];
    logic [W-1:0] q_d[$];
    logic [N-1:0] last_rdy = '0;
    logic         prev_start = 1'b0;

    always_comb for (int k = 0; k < N; k++) data[k*W +: W] = words[k];

    piso_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
        .o_req_ready(ready), .o_ser_start(start), .o_ser_data(sdata),
        .i_ser_done(ser_done), .o_grant_id(gid), .o_busy(busy),
        .o_timeout_err(err), .i_err_clr(clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int i = 0; i < N; i++)
            if (valid[(m_rr + i) % N]) return (m_rr + i) % N;
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += q_cnt[k];
        return s;
    endfunction

    task automatic model_step();
        int w;
        w = winner();
        if (rst) begin
            m_phase = 0; m_rr = 0; m_data = '0; m_grant = 0; m_err = 1'b0;
        end else begin
            if (clr) m_err = 1'b0;
            if (m_phase == 0) begin
                if (w >= 0) begin
                    m_data = words[w]; m_grant = w; m_rr = (w + 1) % N;
                    m_sent = 0; m_phase = 1; q_cnt[w]--;
                end
            end else if (m_phase == 1) begin
                m_sent++;
                if (ser_done) begin
                    m_phase = 2; m_gap = GAPC;
                end else if (m_sent == TO) begin
                    m_err = 1'b1; m_phase = 2; m_gap = GAPC;
                end
            end else begin
                m_gap--;
                if (m_gap == 0) m_phase = 0;
            end
        end
    endtask

    task automatic compare();
        logic [N-1:0] er;
        int w;
        w = winner();
        er = '0;
        if (m_phase == 0 && w >= 0) er[w] = 1'b1;
        chk("ready", ready, er);
        chk("start", start, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("ser_data", sdata, m_data);
        chk("grant_id", gid, m_grant);
        chk("timeout_err", err, m_err);
        if (start) begin
            if (!prev_start) begin q_g.push_back(int'(gid)); q_d.push_back(sdata); end
            run++;
        end else if (run > 0) begin
            q_runs.push_back(run); run = 0;
        end
        if (busy && !start) gapc++;
        else if (gapc > 0) begin q_gaps.push_back(gapc); gapc = 0; end
        if (ready != '0) begin rdy_cyc++; last_rdy = ready; end
        prev_start = start;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < N; k++) valid[k] = (q_cnt[k] > 0);
        scnt = start ? scnt + 1 : 0;
        ser_done = stray || (ser_len > 0 && start && scnt == ser_len);
        #3 compare();
    endtask

    task automatic run_idle(input string nm, input int max);
        int n = 0;
        do begin cyc(); n++; end while ((busy || pending() > 0) && n < max);
        chk({nm, " completes"}, n < max, 1);
    endtask

    task automatic clear();
        q_runs.delete(); q_gaps.delete(); q_g.delete(); q_d.delete(); rdy_cyc = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    initial begin
        int e_g[5] = '{0, 1, 2, 3, 0};
        int n;
        for (int k = 0; k < N; k++) begin words[k] = '0; q_cnt[k] = 0; end
        cyc();
        chk("rst start", start, 0);
        chk("rst busy", busy, 0);
        chk("rst ready", ready, 0);
        chk("rst err", err, 0);
        chk("rst data", sdata, 0);
        chk("rst gid", gid, 0);
        cyc(); rst = 1'b0;

        // single request on requester 1, serializer done after 10 start cycles
        clear(); words[1] = 16'hA5C3; q_cnt[1] = 1; ser_len = 10;
        run_idle("t1", 100);
        chk("t1 n", q_g.size(), 1);
        chk("t1 id", q_g[0], 1);
        chk("t1 word", q_d[0], 16'hA5C3);
        chk("t1 start len", q_runs[0], 10);
        chk("t1 gap len", q_gaps[0], 2);
        chk("t1 ready cycles", rdy_cyc, 1);
        chk("t1 ready onehot", last_rdy, 4'b0010);

        // rr_ptr is now 2: requesters 0 and 3 -> 3 first, then 0
        clear(); words[0] = 16'h0F0F; words[3] = 16'hF0F0; q_cnt[0] = 1; q_cnt[3] = 1; ser_len = 3;
        run_idle("rr2", 100);
        chk("rr2 n", q_g.size(), 2);
        chk("rr2 first", q_g[0], 3);
        chk("rr2 second", q_g[1], 0);

        // all four continuously valid from rr_ptr=0
        do_reset(); clear();
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        q_cnt[0] = 2; q_cnt[1] = 1; q_cnt[2] = 1; q_cnt[3] = 1;
        run_idle("t2", 300);
        chk("t2 n", q_g.size(), 5);
        chk("t2 gaps", q_gaps.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2 order", q_g[i], e_g[i]);
            chk("t2 word", q_d[i], {4{4'(e_g[i] + 1)}});
            chk("t2 gap len", q_gaps[i], 2);
        end

        // move rr_ptr to 3, then requesters 0 and 2 -> 0 then 2
        clear(); q_cnt[2] = 1; run_idle("t3a", 100);
        chk("t3a id", q_g[0], 2);
        clear(); q_cnt[0] = 1; q_cnt[2] = 1; run_idle("t3b", 100);
        chk("t3 n", q_g.size(), 2);
        chk("t3 first", q_g[0], 0);
        chk("t3 second", q_g[1], 2);

        // timeout: done never arrives
        clear(); ser_len = 0; q_cnt[1] = 1; run_idle("t4", 100);
        chk("t4 start len", q_runs[0], 32);
        chk("t4 gap len", q_gaps[0], 2);
        chk("t4 err", err, 1);
        clear(); ser_len = 4; q_cnt[2] = 1; run_idle("t4b", 100);
        chk("t4b start len", q_runs[0], 4);
        chk("t4b err sticky", err, 1);
        stray = 1'b1; cyc(); cyc(); stray = 1'b0;
        chk("idle done ignored", busy, 0);
        clr = 1'b1; cyc(); clr = 1'b0; cyc();
        chk("err cleared", err, 0);

        // clear held while a new timeout fires: set wins on that edge
        clear(); clr = 1'b1; ser_len = 0; q_cnt[0] = 1; n = 0;
        do begin cyc(); n++; end while (q_runs.size() == 0 && n < 100);
        chk("t6 reached", n < 100, 1);
        chk("t6 err set over clr", err, 1);
        cyc();
        chk("t6 err cleared", err, 0);
        clr = 1'b0; run_idle("t6", 50);

        // reset in the 5th SEND cycle; requester 2 stays valid and is re-accepted
        do_reset(); clear(); ser_len = 20;
        words[2] = 16'hBEEF; words[3] = 16'hCAFE; q_cnt[2] = 2; q_cnt[3] = 1; n = 0;
        do begin cyc(); n++; end while (run != 5 && n < 50);
        chk("t5 reached", n < 50, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t5 start", start, 0);
        chk("t5 busy", busy, 0);
        run_idle("t5", 200);
        chk("t5 n", q_g.size(), 3);
        chk("t5 g0", q_g[0], 2);
        chk("t5 g1", q_g[1], 2);
        chk("t5 g2", q_g[2], 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
